// File: rtl/hazard_scoreboard_if.sv
// Handshake bundle between the ID stage and the hazard scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned AW    = 5,
  parameter int unsigned SEL_W = 2
);
  logic             Branch_ID;
  logic             squash_EXE;
  logic             rs1use_ID;
  logic             rs2use_ID;
  logic [AW-1:0]    rs1_ID;
  logic [AW-1:0]    rs2_ID;
  logic [AW-1:0]    rd_ID;
  logic             rd_we_ID;
  logic [1:0]       optype_ID;
  logic             store_ID;
  logic             PC_EN_IF;
  logic             reg_FD_EN;
  logic             reg_FD_flush;
  logic             reg_DE_flush;
  logic [SEL_W-1:0] forward_ctrl_A;
  logic [SEL_W-1:0] forward_ctrl_B;
  logic             forward_ctrl_ls;

  // Pipeline side: drives the decoded ID instruction, consumes controls
  modport master (
    output Branch_ID, squash_EXE, rs1use_ID, rs2use_ID, rs1_ID, rs2_ID,
           rd_ID, rd_we_ID, optype_ID, store_ID,
    input  PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
           forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls
  );

  // Scoreboard side
  modport slave (
    input  Branch_ID, squash_EXE, rs1use_ID, rs2use_ID, rs1_ID, rs2_ID,
           rd_ID, rd_we_ID, optype_ID, store_ID,
    output PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
           forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight producers: stall/flush control,
// per-operand forward selects and late load-to-store data forward flag.
module hazard_scoreboard #(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned AW       = 5,
  parameter int unsigned LAT_ALU  = 1,
  parameter int unsigned LAT_LOAD = 2,
  parameter int unsigned LAT_MUL  = 2,
  parameter int unsigned SEL_W    = 2
) (
  input logic          clk,
  input logic          rst,
  hazard_scoreboard_if.slave hz
);

  localparam int unsigned NSLOT = DEPTH - 1;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ALU  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic [1:0]    op;
  } slot_t;

  slot_t slot_q [1:NSLOT];
  slot_t slot_d [1:NSLOT];
  logic  live   [1:NSLOT];
  logic  ls_q;
  logic  ls_d;

  logic        hit_a, hit_b;
  int unsigned age_a, age_b;
  logic [1:0]  op_a, op_b;
  int unsigned need_a, need_b;
  logic        haz_a, haz_b;
  logic        stall;
  logic        issue;

  // Age at which a producer of the given class has its result available
  function automatic int unsigned ready_age(input logic [1:0] op);
    case (op)
      OP_ALU:  return LAT_ALU;
      OP_LOAD: return LAT_LOAD;
      OP_MUL:  return LAT_MUL;
      default: return 0;
    endcase
  endfunction

  // A squashed EXE instruction no longer produces anything
  always_comb begin
    for (int unsigned k = 1; k <= NSLOT; k++) begin
      live[k] = slot_q[k].valid;
    end
    live[1] = slot_q[1].valid & ~hz.squash_EXE;
  end

  // Youngest matching producer per source operand; x0 never matches
  always_comb begin
    hit_a = 1'b0;
    age_a = 0;
    op_a  = OP_NONE;
    hit_b = 1'b0;
    age_b = 0;
    op_b  = OP_NONE;
    for (int unsigned k = NSLOT; k >= 1; k--) begin
      if (live[k] && (slot_q[k].rd == hz.rs1_ID) && (hz.rs1_ID != '0)) begin
        hit_a = 1'b1;
        age_a = k;
        op_a  = slot_q[k].op;
      end
      if (live[k] && (slot_q[k].rd == hz.rs2_ID) && (hz.rs2_ID != '0)) begin
        hit_b = 1'b1;
        age_b = k;
        op_b  = slot_q[k].op;
      end
    end
  end

  // Hazard detection; store data is consumed one stage later than rs2
  always_comb begin
    need_a = ready_age(op_a);
    need_b = ready_age(op_b);
    if (hz.store_ID && (need_b != 0)) begin
      need_b = need_b - 1;
    end
    haz_a = hz.rs1use_ID && hit_a && (age_a < need_a);
    haz_b = hz.rs2use_ID && hit_b && (age_b < need_b);
    stall = haz_a | haz_b;
    issue = !stall && hz.rd_we_ID && (hz.rd_ID != '0) && (hz.optype_ID != OP_NONE);
    ls_d  = hz.store_ID && !stall && hz.rs2use_ID && hit_b && (age_b == need_b)
            && (op_b == OP_LOAD) && !hz.squash_EXE;
  end

  // Pipeline controls and forward selects; a stall defers any branch
  always_comb begin
    hz.PC_EN_IF     = 1'b1;
    hz.reg_FD_EN    = 1'b1;
    hz.reg_FD_flush = 1'b0;
    hz.reg_DE_flush = 1'b0;
    if (stall) begin
      hz.PC_EN_IF     = 1'b0;
      hz.reg_FD_EN    = 1'b0;
      hz.reg_DE_flush = 1'b1;
    end else if (hz.Branch_ID) begin
      hz.reg_FD_flush = 1'b1;
    end
    hz.forward_ctrl_A  = SEL_W'(age_a);
    hz.forward_ctrl_B  = SEL_W'(age_b);
    hz.forward_ctrl_ls = ls_q;
  end

  // Next scoreboard contents: new entry (or bubble) in slot 1, older slots shift
  always_comb begin
    slot_d[1].valid = issue;
    slot_d[1].rd    = hz.rd_ID;
    slot_d[1].op    = hz.optype_ID;
    for (int unsigned k = 2; k <= NSLOT; k++) begin
      slot_d[k]       = slot_q[k-1];
      slot_d[k].valid = live[k-1];
    end
  end

  // Scoreboard and late-forward flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 1; k <= NSLOT; k++) begin
        slot_q[k] <= '0;
      end
      ls_q <= 1'b0;
    end else begin
      for (int unsigned k = 1; k <= NSLOT; k++) begin
        slot_q[k] <= slot_d[k];
      end
      ls_q <= ls_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed vector table, reset corner sequences and
// randomized traffic against an in-flight producer list model.
module tb_hazard_scoreboard;

  localparam int unsigned DEPTH = 3;
  localparam int unsigned AW    = 5;
  localparam int unsigned SEL_W = 2;
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MUL  = 2;

  localparam logic [1:0] N  = 2'd0;
  localparam logic [1:0] AL = 2'd1;
  localparam logic [1:0] LD = 2'd2;
  localparam logic [1:0] MU = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_scoreboard_if #(.AW(AW), .SEL_W(SEL_W)) hz ();

  hazard_scoreboard #(
    .DEPTH(DEPTH), .AW(AW), .LAT_ALU(LAT_ALU), .LAT_LOAD(LAT_LOAD),
    .LAT_MUL(LAT_MUL), .SEL_W(SEL_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       br, sq, u1, u2;
    logic [4:0] rs1, rs2, rd;
    logic       we;
    logic [1:0] op;
    logic       st;
  } in_t;

  typedef struct {
    logic       pc, fden, fdfl, defl;
    logic [1:0] fa, fb;
    logic       ls;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  function automatic in_t ins(input logic [1:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2,
                              input logic st, input logic br, input logic sq);
    in_t v;
    v.op = op; v.rd = rd; v.we = (op != N);
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.st = st; v.br = br; v.sq = sq;
    return v;
  endfunction

  function automatic out_t outs(input logic pc, input logic fden, input logic fdfl,
                                input logic defl, input logic [1:0] fa,
                                input logic [1:0] fb, input logic ls);
    out_t o;
    o.pc = pc; o.fden = fden; o.fdfl = fdfl; o.defl = defl;
    o.fa = fa; o.fb = fb; o.ls = ls;
    return o;
  endfunction

  function automatic out_t ok(input logic [1:0] fa, input logic [1:0] fb, input logic ls);
    return outs(1'b1, 1'b1, 1'b0, 1'b0, fa, fb, ls);
  endfunction

  function automatic out_t stl(input logic [1:0] fa, input logic [1:0] fb);
    return outs(1'b0, 1'b0, 1'b0, 1'b1, fa, fb, 1'b0);
  endfunction

  function automatic out_t brn(input logic [1:0] fa, input logic [1:0] fb);
    return outs(1'b1, 1'b1, 1'b1, 1'b0, fa, fb, 1'b0);
  endfunction

  task automatic drive(input in_t v);
    hz.Branch_ID  = v.br;
    hz.squash_EXE = v.sq;
    hz.rs1use_ID  = v.u1;
    hz.rs2use_ID  = v.u2;
    hz.rs1_ID     = v.rs1;
    hz.rs2_ID     = v.rs2;
    hz.rd_ID      = v.rd;
    hz.rd_we_ID   = v.we;
    hz.optype_ID  = v.op;
    hz.store_ID   = v.st;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    check({tag, ".PC_EN_IF"},        8'(hz.PC_EN_IF),        8'(e.pc));
    check({tag, ".reg_FD_EN"},       8'(hz.reg_FD_EN),       8'(e.fden));
    check({tag, ".reg_FD_flush"},    8'(hz.reg_FD_flush),    8'(e.fdfl));
    check({tag, ".reg_DE_flush"},    8'(hz.reg_DE_flush),    8'(e.defl));
    check({tag, ".forward_ctrl_A"},  8'(hz.forward_ctrl_A),  8'(e.fa));
    check({tag, ".forward_ctrl_B"},  8'(hz.forward_ctrl_B),  8'(e.fb));
    check({tag, ".forward_ctrl_ls"}, 8'(hz.forward_ctrl_ls), 8'(e.ls));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    drive(ins(N, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 check_out("reset", ok(0, 0, 0));
    #1 rst = 1'b0;
    step();
  endtask

  // ---------------- reference model: list of in-flight producers ----------------
  typedef struct {
    logic [4:0] rd;
    logic [1:0] op;
    int         age;
  } prod_t;

  prod_t inflight[$];
  bit    m_issue;
  bit    m_ls;
  bit    m_ls_next;

  function automatic int lat(input logic [1:0] op);
    case (op)
      AL:      return LAT_ALU;
      LD:      return LAT_LOAD;
      MU:      return LAT_MUL;
      default: return 0;
    endcase
  endfunction

  task automatic find(input logic [4:0] src, input logic sq,
                      output int age, output logic [1:0] op);
    age = 0;
    op  = N;
    if (src != 0) begin
      foreach (inflight[j]) begin
        if (inflight[j].rd == src && !(sq && inflight[j].age == 1) &&
            (age == 0 || inflight[j].age < age)) begin
          age = inflight[j].age;
          op  = inflight[j].op;
        end
      end
    end
  endtask

  task automatic model_eval(input in_t v, output out_t e);
    int age_a, age_b, need_a, need_b;
    logic [1:0] op_a, op_b;
    bit stall;
    find(v.rs1, v.sq, age_a, op_a);
    find(v.rs2, v.sq, age_b, op_b);
    need_a = lat(op_a);
    need_b = lat(op_b) - ((v.st && age_b != 0) ? 1 : 0);
    stall = (v.u1 && age_a != 0 && age_a < need_a) ||
            (v.u2 && age_b != 0 && age_b < need_b);
    if (stall)     e = stl(2'(age_a), 2'(age_b));
    else if (v.br) e = brn(2'(age_a), 2'(age_b));
    else           e = ok(2'(age_a), 2'(age_b), 1'b0);
    e.ls = m_ls;
    m_issue   = !stall && v.we && v.rd != 0 && v.op != N;
    m_ls_next = v.st && !stall && v.u2 && age_b != 0 && age_b == need_b &&
                op_b == LD && !v.sq;
  endtask

  task automatic model_update(input in_t v);
    prod_t nq[$];
    foreach (inflight[j]) begin
      if (!(v.sq && inflight[j].age == 1) && inflight[j].age + 1 <= int'(DEPTH) - 1) begin
        prod_t p;
        p = inflight[j];
        p.age = p.age + 1;
        nq.push_back(p);
      end
    end
    if (m_issue) begin
      prod_t p;
      p.rd = v.rd; p.op = v.op; p.age = 1;
      nq.push_back(p);
    end
    inflight = nq;
    m_ls = m_ls_next;
  endtask

  // ---------------- test ----------------
  vec_t tbl[25];

  initial begin
    tbl[0]  = '{ins(AL, 5, 1, 1, 2, 1, 0, 0, 0),  ok(0, 0, 0)};
    tbl[1]  = '{ins(AL, 6, 5, 1, 1, 1, 0, 0, 0),  ok(1, 0, 0)};
    tbl[2]  = '{ins(AL, 11, 3, 1, 4, 1, 0, 0, 0), ok(0, 0, 0)};
    tbl[3]  = '{ins(AL, 12, 6, 1, 0, 1, 0, 0, 0), ok(2, 0, 0)};
    tbl[4]  = '{ins(LD, 7, 2, 1, 0, 0, 0, 0, 0),  ok(0, 0, 0)};
    tbl[5]  = '{ins(AL, 8, 7, 1, 0, 1, 0, 0, 0),  stl(1, 0)};
    tbl[6]  = '{ins(AL, 8, 7, 1, 0, 1, 0, 0, 0),  ok(2, 0, 0)};
    tbl[7]  = '{ins(LD, 7, 2, 1, 0, 0, 0, 0, 0),  ok(0, 0, 0)};
    tbl[8]  = '{ins(N, 0, 2, 1, 7, 1, 1, 0, 0),   ok(0, 1, 0)};
    tbl[9]  = '{ins(N, 0, 0, 0, 0, 0, 0, 0, 0),   ok(0, 0, 1)};
    tbl[10] = '{ins(N, 0, 0, 0, 0, 0, 0, 0, 0),   ok(0, 0, 0)};
    tbl[11] = '{ins(AL, 5, 1, 1, 2, 1, 0, 0, 0),  ok(0, 0, 0)};
    tbl[12] = '{ins(AL, 5, 1, 1, 2, 1, 0, 0, 0),  ok(0, 0, 0)};
    tbl[13] = '{ins(AL, 13, 5, 1, 0, 1, 0, 0, 0), ok(1, 0, 0)};
    tbl[14] = '{ins(AL, 0, 1, 1, 1, 1, 0, 0, 0),  ok(0, 0, 0)};
    tbl[15] = '{ins(N, 0, 0, 1, 0, 1, 0, 0, 0),   ok(0, 0, 0)};
    tbl[16] = '{ins(LD, 7, 2, 1, 0, 0, 0, 0, 0),  ok(0, 0, 0)};
    tbl[17] = '{ins(AL, 8, 7, 1, 0, 1, 0, 0, 1),  ok(0, 0, 0)};
    tbl[18] = '{ins(AL, 14, 7, 1, 0, 1, 0, 0, 0), ok(0, 0, 0)};
    tbl[19] = '{ins(LD, 7, 2, 1, 0, 0, 0, 0, 0),  ok(0, 0, 0)};
    tbl[20] = '{ins(AL, 8, 7, 1, 0, 1, 0, 1, 0),  stl(1, 0)};
    tbl[21] = '{ins(AL, 8, 7, 1, 0, 1, 0, 1, 0),  brn(2, 0)};
    tbl[22] = '{ins(MU, 15, 1, 1, 2, 1, 0, 0, 0), ok(0, 0, 0)};
    tbl[23] = '{ins(AL, 16, 15, 1, 0, 1, 0, 0, 0), stl(1, 0)};
    tbl[24] = '{ins(AL, 16, 15, 1, 0, 1, 0, 0, 0), ok(2, 0, 0)};

    // directed table
    do_reset();
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].i);
      #3 check_out($sformatf("vec%0d", i), tbl[i].o);
      step();
    end

    // async reset while the late-forward flag is set and a forward is live
    do_reset();
    drive(ins(LD, 7, 2, 1, 0, 0, 0, 0, 0));
    step();
    drive(ins(N, 0, 2, 1, 7, 1, 1, 0, 0));
    #3 check_out("rstA.store", ok(0, 1, 0));
    step();
    drive(ins(AL, 8, 7, 1, 0, 1, 0, 0, 0));
    #3 check_out("rstA.pre", ok(2, 0, 1));
    #2 rst = 1'b1;
    #1 check_out("rstA.in", ok(0, 0, 0));
    #1 rst = 1'b0;
    step();

    // async reset in the middle of a load-use stall
    drive(ins(LD, 7, 2, 1, 0, 0, 0, 0, 0));
    step();
    drive(ins(AL, 8, 7, 1, 0, 1, 0, 0, 0));
    #3 check_out("rstB.pre", stl(1, 0));
    #2 rst = 1'b1;
    #1 check_out("rstB.in", ok(0, 0, 0));
    #1 rst = 1'b0;
    step();
    #3 check_out("rstB.post", ok(0, 0, 0));
    step();

    // randomized traffic against the model
    do_reset();
    inflight.delete();
    m_ls = 1'b0;
    for (int c = 0; c < 600; c++) begin
      in_t  v;
      out_t e;
      v.op  = 2'($urandom_range(0, 3));
      v.rd  = 5'($urandom_range(0, 7));
      v.we  = (v.op != N) && ($urandom_range(0, 7) != 0);
      v.rs1 = 5'($urandom_range(0, 7));
      v.rs2 = 5'($urandom_range(0, 7));
      v.u1  = 1'($urandom_range(0, 1));
      v.u2  = 1'($urandom_range(0, 1));
      v.st  = (v.op == N) && ($urandom_range(0, 1) != 0);
      if (v.st) v.u2 = 1'b1;
      v.br  = ($urandom_range(0, 7) == 0);
      v.sq  = ($urandom_range(0, 7) == 0);
      drive(v);
      model_eval(v, e);
      #3 check_out($sformatf("rnd%0d", c), e);
      @(posedge clk);
      model_update(v);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
